slink_tx_app_mux: RTL and testbench
===================================

// Module: slink_tx_app_mux
// PURPOSE
//  Packet-aware 2:1 mux between the application TX source and the BIST TX generator, in front of the S-Link link-layer TX.
//  - Source select follows bist_active, but changes only on a packet boundary, so no packet is ever split.
//  - The non-selected source is stalled (its advance held 0).
// PARAMETERS
//  APP_DATA_WIDTH  32    width of app_data on all three interfaces; multiple of 8
//  SHORT_PKT_MAX   8'h2F data_id <= this is a short packet (header beat only)
// PORTS
//  clk             in   1    link clock
//  reset           in   1    asynchronous, active-low reset
//  bist_active     in   1    request BIST source; already synchronised to clk
//  app_sop         in   1    app header beat valid
//  app_data_id     in   8    app data id
//  app_word_count  in   16   app word count (bytes; short-pkt payload field)
//  app_app_data    in   AW   app payload
//  app_advance     out  1    beat accepted from app
//  bist_sop/bist_data_id/bist_word_count/bist_app_data  in  1/8/16/AW  BIST source, same meaning
//  bist_advance    out  1    beat accepted from BIST
//  tx_sop/tx_data_id/tx_word_count/tx_app_data          out 1/8/16/AW  to link layer
//  tx_advance      in   1    link layer accepts current beat
//  sel_bist        out  1    1 = BIST source currently selected
//  in_packet       out  1    1 = payload beats of a long packet outstanding
//  cnt_clear       in   1    clear packet counters (ignored without macro)
//  app_pkt_cnt     out  16   completed app packets (0 without macro)
//  bist_pkt_cnt    out  16   completed BIST packets (0 without macro)
// BEHAVIOUR
//  - Data path is combinational; zero added latency. tx_* = selected source's sop/id/wc/data.
//  - Selected advance = tx_advance; non-selected advance = 0.
//  - Beat transfer: cycle with tx_advance=1 while a packet is active, or with tx_sop=1 in an idle state.
//  - BYTES = AW/8.
//  - Long packet (data_id > SHORT_PKT_MAX): header beat, then PB = ceil(word_count/BYTES) payload beats.
//    - Header data_id/wc are not re-checked during payload beats.
//  - Short packet: header beat only.
//  - Long wc=0 has PB = 0 and ends on the header beat.
//  - FSM states: APP_IDLE, APP_PKT, BIST_IDLE, BIST_PKT. Reset -> APP_IDLE.
//    - X_IDLE, header accepted with PB>0: -> X_PKT; beat_cnt <= PB.
//    - X_PKT: beat_cnt decrements on each accepted beat; the beat taking it 1->0 is the last -> X_IDLE.
//    - APP_IDLE & bist_active=1 & no header accepted this cycle: -> BIST_IDLE.
//    - BIST_IDLE & bist_active=0 & no header accepted this cycle: -> APP_IDLE.
//    - bist_active change mid-packet: held off; switch evaluated in the idle state, first cycle after last beat.
//    - Header accepted in same cycle as bist_active change: packet wins, switch deferred.
//    - Last beat coincides with bist_active change: X_IDLE first, switch one cycle later. The new source is never presented in the last-beat cycle.
//  - beat_cnt is 16 bits, computed as (wc + BYTES-1) >> log2(BYTES) in 17-bit arithmetic. wc=16'hFFFF must not wrap.
//  - sel_bist = state is BIST_*; in_packet = state is X_PKT.
//  - Reset values: sel_bist=0, in_packet=0, counters 0, beat_cnt 0.
//    - tx_* reflect app inputs; bist_advance=0; app_advance=tx_advance.
//  - Reset mid-packet: immediate return to APP_IDLE; partial packet abandoned.
// CONFIGURATION
//  SLINK_TX_MUX_PKT_CNT_EN defined:
//    - per-source 16-bit packet counters, +1 on each packet's final beat (header beat for short/PB=0).
//    - Saturate at 16'hFFFF; cnt_clear=1 zeroes both, with priority over increment.
//  Not defined: no counter flops; app_pkt_cnt=bist_pkt_cnt=0; cnt_clear unused.
// TESTING
//  1. Reset, app short pkt id=8'h10, tx_advance=1 -> one beat on tx; bist_advance=0; app_pkt_cnt=1 (macro).
//  2. AW=32, app long id=8'h40 wc=10; bist_active rises after header -> 1 header + 3 payload beats from app.
//     sel_bist rises the cycle after APP_IDLE is reached.
//  3. BIST selected, tx_advance=0 for 5 cycles mid-packet -> tx_* stable, beat_cnt frozen.
//     App stalled: app_advance=0 throughout.
//  4. Long wc=0 and wc=16'hFFFF (AW=32) -> in_packet never set; 16384 payload beats respectively.
//  5. Assert reset (low) in BIST_PKT with beat_cnt=3 -> sel_bist=0, in_packet=0, tx_* follow app immediately.
//  6. Macro on: 65536 BIST short pkts -> bist_pkt_cnt=16'hFFFF; cnt_clear with a final beat -> 0.

Source files
------------

// File: rtl/slink_tx_app_mux.sv
// Packet-aware 2:1 mux (app / BIST) in front of the S-Link TX link layer; optional packet counters under SLINK_TX_MUX_PKT_CNT_EN.
// Latency: zero, the data path is combinational. Backpressure: tx_advance goes to the selected source, the other source's advance is held 0.
module slink_tx_app_mux #(
    parameter int         APP_DATA_WIDTH = 32,
    parameter logic [7:0] SHORT_PKT_MAX  = 8'h2F
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_bist_active,

    input  logic                      i_app_sop,
    input  logic [7:0]                i_app_data_id,
    input  logic [15:0]               i_app_word_count,
    input  logic [APP_DATA_WIDTH-1:0] i_app_app_data,
    output logic                      o_app_advance,

    input  logic                      i_bist_sop,
    input  logic [7:0]                i_bist_data_id,
    input  logic [15:0]               i_bist_word_count,
    input  logic [APP_DATA_WIDTH-1:0] i_bist_app_data,
    output logic                      o_bist_advance,

    output logic                      o_tx_sop,
    output logic [7:0]                o_tx_data_id,
    output logic [15:0]               o_tx_word_count,
    output logic [APP_DATA_WIDTH-1:0] o_tx_app_data,
    input  logic                      i_tx_advance,

    output logic                      o_sel_bist,
    output logic                      o_in_packet,

    input  logic                      i_cnt_clear,
    output logic [15:0]               o_app_pkt_cnt,
    output logic [15:0]               o_bist_pkt_cnt
);

    localparam int BYTES = APP_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);

    typedef enum logic [1:0] {
        APP_IDLE  = 2'd0,
        APP_PKT   = 2'd1,
        BIST_IDLE = 2'd2,
        BIST_PKT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_beat_cnt;
    logic [15:0] w_beat_cnt_nxt;

    logic        w_sel_bist;
    logic        w_idle;
    logic        w_long;
    logic [16:0] w_pb17;
    logic [15:0] w_pb;
    logic        w_pb_zero;
    logic        w_hdr_acc;
    logic        w_pay_acc;
    logic        w_last;
    logic        w_pkt_done;

    assign w_sel_bist = (r_state == BIST_IDLE) || (r_state == BIST_PKT);
    assign w_idle     = (r_state == APP_IDLE)  || (r_state == BIST_IDLE);

    assign o_tx_sop        = w_sel_bist ? i_bist_sop        : i_app_sop;
    assign o_tx_data_id    = w_sel_bist ? i_bist_data_id    : i_app_data_id;
    assign o_tx_word_count = w_sel_bist ? i_bist_word_count : i_app_word_count;
    assign o_tx_app_data   = w_sel_bist ? i_bist_app_data   : i_app_app_data;

    assign o_app_advance  = w_sel_bist ? 1'b0 : i_tx_advance;
    assign o_bist_advance = w_sel_bist ? i_tx_advance : 1'b0;

    assign o_sel_bist  = w_sel_bist;
    assign o_in_packet = !w_idle;

    // 17-bit round-up so a word count of 16'hFFFF does not wrap to zero beats.
    assign w_pb17    = ({1'b0, o_tx_word_count} + 17'(BYTES - 1)) >> SHIFT;
    assign w_pb      = w_pb17[15:0];
    assign w_pb_zero = (w_pb == 16'd0);
    assign w_long    = (o_tx_data_id > SHORT_PKT_MAX);

    assign w_hdr_acc  = w_idle && o_tx_sop;
    assign w_pay_acc  = !w_idle && i_tx_advance;
    assign w_last     = w_pay_acc && (r_beat_cnt == 16'd1);
    assign w_pkt_done = (w_hdr_acc && (!w_long || w_pb_zero)) || w_last;

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            APP_IDLE: begin
                if (w_hdr_acc && w_long && !w_pb_zero) begin
                    w_state_nxt    = APP_PKT;
                    w_beat_cnt_nxt = w_pb;
                end else if (!w_hdr_acc && i_bist_active) begin
                    w_state_nxt = BIST_IDLE;
                end
            end
            APP_PKT: begin
                if (w_pay_acc) begin
                    w_beat_cnt_nxt = r_beat_cnt - 16'd1;
                end
                if (w_last) begin
                    w_state_nxt = APP_IDLE;
                end
            end
            BIST_IDLE: begin
                if (w_hdr_acc && w_long && !w_pb_zero) begin
                    w_state_nxt    = BIST_PKT;
                    w_beat_cnt_nxt = w_pb;
                end else if (!w_hdr_acc && !i_bist_active) begin
                    w_state_nxt = APP_IDLE;
                end
            end
            BIST_PKT: begin
                if (w_pay_acc) begin
                    w_beat_cnt_nxt = r_beat_cnt - 16'd1;
                end
                if (w_last) begin
                    w_state_nxt = BIST_IDLE;
                end
            end
            default: begin
                w_state_nxt    = APP_IDLE;
                w_beat_cnt_nxt = 16'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= APP_IDLE;
            r_beat_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifdef SLINK_TX_MUX_PKT_CNT_EN
    logic [15:0] r_app_pkt_cnt;
    logic [15:0] r_bist_pkt_cnt;

    // Clear wins over a coincident final beat; counters stick at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_app_pkt_cnt  <= 16'd0;
            r_bist_pkt_cnt <= 16'd0;
        end else if (i_cnt_clear) begin
            r_app_pkt_cnt  <= 16'd0;
            r_bist_pkt_cnt <= 16'd0;
        end else if (w_pkt_done) begin
            if (w_sel_bist) begin
                if (r_bist_pkt_cnt != 16'hFFFF) begin
                    r_bist_pkt_cnt <= r_bist_pkt_cnt + 16'd1;
                end
            end else begin
                if (r_app_pkt_cnt != 16'hFFFF) begin
                    r_app_pkt_cnt <= r_app_pkt_cnt + 16'd1;
                end
            end
        end
    end

    assign o_app_pkt_cnt  = r_app_pkt_cnt;
    assign o_bist_pkt_cnt = r_bist_pkt_cnt;
`else
    logic [1:0] w_unused_sigs;
    assign w_unused_sigs  = {i_cnt_clear, w_pkt_done};
    assign o_app_pkt_cnt  = 16'd0;
    assign o_bist_pkt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_slink_tx_app_mux.sv
// Directed bench for slink_tx_app_mux with APP_DATA_WIDTH=32 (4 bytes per payload beat).
module tb_slink_tx_app_mux;

`ifdef SLINK_TX_MUX_PKT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bist_active;
    logic        app_sop, bist_sop;
    logic [7:0]  app_id, bist_id;
    logic [15:0] app_wc, bist_wc;
    logic [31:0] app_data, bist_data;
    logic        app_adv, bist_adv;
    logic        tx_sop;
    logic [7:0]  tx_id;
    logic [15:0] tx_wc;
    logic [31:0] tx_data;
    logic        tx_adv;
    logic        sel_bist, in_packet;
    logic        cnt_clear;
    logic [15:0] app_cnt, bist_cnt;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    slink_tx_app_mux #(.APP_DATA_WIDTH(32), .SHORT_PKT_MAX(8'h2F)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_bist_active    (bist_active),
        .i_app_sop        (app_sop),
        .i_app_data_id    (app_id),
        .i_app_word_count (app_wc),
        .i_app_app_data   (app_data),
        .o_app_advance    (app_adv),
        .i_bist_sop       (bist_sop),
        .i_bist_data_id   (bist_id),
        .i_bist_word_count(bist_wc),
        .i_bist_app_data  (bist_data),
        .o_bist_advance   (bist_adv),
        .o_tx_sop         (tx_sop),
        .o_tx_data_id     (tx_id),
        .o_tx_word_count  (tx_wc),
        .o_tx_app_data    (tx_data),
        .i_tx_advance     (tx_adv),
        .o_sel_bist       (sel_bist),
        .o_in_packet      (in_packet),
        .i_cnt_clear      (cnt_clear),
        .o_app_pkt_cnt    (app_cnt),
        .o_bist_pkt_cnt   (bist_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0; bist_active = 1'b0; cnt_clear = 1'b0;
        app_sop = 1'b0; app_id = 8'h10; app_wc = 16'd0; app_data = 32'hA5A5_0001;
        bist_sop = 1'b0; bist_id = 8'h20; bist_wc = 16'd0; bist_data = 32'hB1B1_0002;
        tx_adv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel_bist", 32'(sel_bist), 32'd0);
        chk("rst_in_packet", 32'(in_packet), 32'd0);
        chk("rst_tx_id", 32'(tx_id), 32'h10);
        chk("rst_tx_data", tx_data, 32'hA5A5_0001);
        chk("rst_bist_adv", 32'(bist_adv), 32'd0);
        chk("rst_app_adv1", 32'(app_adv), 32'd1);
        tx_adv = 1'b0;
        #1;
        chk("rst_app_adv0", 32'(app_adv), 32'd0);
        chk("rst_app_cnt", 32'(app_cnt), 32'd0);
        chk("rst_bist_cnt", 32'(bist_cnt), 32'd0);
        tx_adv = 1'b1;
        rst_n = 1'b1;
        tick();

        // Test 1: app short packet
        app_sop = 1'b1; app_id = 8'h10;
        #1;
        chk("t1_tx_sop", 32'(tx_sop), 32'd1);
        chk("t1_app_adv", 32'(app_adv), 32'd1);
        chk("t1_bist_adv", 32'(bist_adv), 32'd0);
        tick();
        app_sop = 1'b0;
        #1;
        chk("t1_in_packet", 32'(in_packet), 32'd0);
        chk("t1_app_cnt", 32'(app_cnt), cexp(1));

        // Header accepted while bist_active rises: packet wins, no switch
        bist_active = 1'b1; app_sop = 1'b1;
        tick();
        app_sop = 1'b0; bist_active = 1'b0;
        #1;
        chk("tie_sel_bist", 32'(sel_bist), 32'd0);
        chk("tie_app_cnt", 32'(app_cnt), cexp(2));

        // Test 2: app long id 40 wc 10 -> 3 payload beats, bist_active rises after header
        app_id = 8'h40; app_wc = 16'd10; app_sop = 1'b1;
        tick();
        app_sop = 1'b0; bist_active = 1'b1;
        #1;
        chk("t2_in_packet_hdr", 32'(in_packet), 32'd1);
        chk("t2_sel_hdr", 32'(sel_bist), 32'd0);
        for (int i = 0; i < 3; i++) begin
            app_data = 32'hA5A5_0010 + 32'(i);
            #1;
            chk("t2_tx_data", tx_data, 32'hA5A5_0010 + 32'(i));
            chk("t2_app_adv", 32'(app_adv), 32'd1);
            chk("t2_sel", 32'(sel_bist), 32'd0);
            tick();
            chk("t2_in_packet", 32'(in_packet), (i < 2) ? 32'd1 : 32'd0);
        end
        chk("t2_sel_idle", 32'(sel_bist), 32'd0);
        tick();
        chk("t2_sel_switched", 32'(sel_bist), 32'd1);
        chk("t2_app_cnt", 32'(app_cnt), cexp(3));

        // Test 3: BIST long id 50 wc 20 -> 5 beats, stall 5 cycles after the first
        bist_id = 8'h50; bist_wc = 16'd20; bist_sop = 1'b1;
        tick();
        bist_sop = 1'b0;
        #1;
        chk("t3_in_packet_hdr", 32'(in_packet), 32'd1);
        chk("t3_tx_id", 32'(tx_id), 32'h50);
        tick();
        tx_adv = 1'b0; app_sop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_stall_app_adv", 32'(app_adv), 32'd0);
            chk("t3_stall_bist_adv", 32'(bist_adv), 32'd0);
            chk("t3_stall_tx_data", tx_data, 32'hB1B1_0002);
            chk("t3_stall_in_packet", 32'(in_packet), 32'd1);
            tick();
        end
        app_sop = 1'b0; tx_adv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_app_adv", 32'(app_adv), 32'd0);
            tick();
            chk("t3_in_packet", 32'(in_packet), (i < 3) ? 32'd1 : 32'd0);
        end
        chk("t3_bist_cnt", 32'(bist_cnt), cexp(1));

        // Test 4: back to app, long wc=0 and wc=FFFF
        bist_active = 1'b0;
        tick();
        chk("t4_sel_app", 32'(sel_bist), 32'd0);
        app_id = 8'h40; app_wc = 16'd0; app_sop = 1'b1;
        tick();
        app_sop = 1'b0;
        #1;
        chk("t4_wc0_in_packet", 32'(in_packet), 32'd0);
        chk("t4_wc0_app_cnt", 32'(app_cnt), cexp(4));
        app_wc = 16'hFFFF; app_sop = 1'b1;
        tick();
        app_sop = 1'b0;
        chk("t4_max_in_packet", 32'(in_packet), 32'd1);
        n = 0;
        while (n < 20000) begin
            tick();
            n++;
            if (!in_packet) break;
        end
        chk("t4_max_beats", 32'(n), 32'd16384);
        chk("t4_max_app_cnt", 32'(app_cnt), cexp(5));

        // Test 5: reset asserted in BIST_PKT with 3 beats outstanding
        bist_active = 1'b1;
        tick();
        chk("t5_sel_bist", 32'(sel_bist), 32'd1);
        bist_id = 8'h50; bist_wc = 16'd12; bist_sop = 1'b1;
        tick();
        bist_sop = 1'b0;
        #1;
        chk("t5_in_packet", 32'(in_packet), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sel", 32'(sel_bist), 32'd0);
        chk("t5_rst_in_packet", 32'(in_packet), 32'd0);
        chk("t5_rst_tx_data", tx_data, app_data);
        chk("t5_rst_tx_id", 32'(tx_id), 32'h40);
        chk("t5_rst_bist_adv", 32'(bist_adv), 32'd0);
        chk("t5_rst_app_cnt", 32'(app_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_post_sel", 32'(sel_bist), 32'd1);

        // Test 6: BIST short packets saturate the counter, then clear on a final beat
`ifdef SLINK_TX_MUX_PKT_CNT_EN
        bist_id = 8'h20; bist_sop = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("t6_bist_sat", 32'(bist_cnt), 32'hFFFF);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0; bist_sop = 1'b0;
        #1;
        chk("t6_bist_clear", 32'(bist_cnt), 32'd0);
        chk("t6_app_cnt", 32'(app_cnt), 32'd0);
`else
        bist_id = 8'h20; bist_sop = 1'b1; cnt_clear = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cnt_clear = 1'b0; bist_sop = 1'b0;
        chk("t6_bist_cnt_off", 32'(bist_cnt), 32'd0);
        chk("t6_app_cnt_off", 32'(app_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
